// File: rtl/adc_spi_reader.sv
// ==== adc_spi_reader: receive-only SPI mode-0 master reading one 16-bit frame from a 12-bit ADC per request.
// ==== Optional ADC_OFFSET_BIN_EN converts offset-binary codes to two's complement. rev 1.0
`default_nettype none
`timescale 1ns/1ps

module adc_spi_reader #(
   parameter int CLK_DIV    = 2,   // system clocks per SCLK half-period (>=1)
   parameter int FRAME_BITS = 16,  // SCLK pulses per frame
   parameter int DATA_W     = 12,  // data bits kept from the frame tail
   parameter int CS_SETUP   = 2,   // clocks from CS_n fall to first SCLK phase
   parameter int QUIET      = 2    // clocks CS_n high before publish (>=1)
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              adc_data_req_i,
   output logic              adc_data_rdy_o,
   output logic [DATA_W-1:0] adc_data_o,
   output logic              spi_cs_n_o,
   output logic              spi_sclk_o,
   input  logic              spi_miso_i,
   output logic              frame_err_o,
   output logic              overrun_o
);

   localparam int CNT_MAX_A = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
   localparam int CNT_MAX   = (CNT_MAX_A > QUIET) ? CNT_MAX_A : QUIET;
   localparam int CNT_W     = $clog2(CNT_MAX + 1);
   localparam int BIT_W     = $clog2(FRAME_BITS + 1);

   localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(QUIET - 2);
   localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(FRAME_BITS - 1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SETUP   = 3'd1,
      SHIFT   = 3'd2,
      CS_HOLD = 3'd3,
      PUBLISH = 3'd4
   } state_t;

   state_t                  state, state_nxt;
   logic                    req_q, req_q_d;
   logic                    start;
   logic [CNT_W-1:0]        cnt, cnt_nxt;
   logic [BIT_W-1:0]        bit_cnt, bit_cnt_nxt;
   logic [FRAME_BITS-1:0]   shreg, shreg_nxt;
   logic                    sclk_nxt, cs_n_nxt, rdy_nxt, ferr_nxt, ovr_nxt;
   logic [DATA_W-1:0]       data_nxt;
   logic [DATA_W-1:0]       sample;
   logic                    lead_err;

   assign start = req_q & ~req_q_d;

   generate
      if (FRAME_BITS > DATA_W) begin : g_lead
         assign lead_err = |shreg[FRAME_BITS-1:DATA_W];
      end else begin : g_no_lead
         assign lead_err = 1'b0;
      end
   endgenerate

`ifdef ADC_OFFSET_BIN_EN
   // Flipping the MSB maps offset-binary onto two's complement.
   assign sample = {~shreg[DATA_W-1], shreg[DATA_W-2:0]};
`else
   assign sample = shreg[DATA_W-1:0];
`endif

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      bit_cnt_nxt = bit_cnt;
      shreg_nxt   = shreg;
      sclk_nxt    = spi_sclk_o;
      cs_n_nxt    = spi_cs_n_o;
      rdy_nxt     = adc_data_rdy_o;
      data_nxt    = adc_data_o;
      ferr_nxt    = frame_err_o;
      ovr_nxt     = overrun_o | (start & (state != IDLE));

      case (state)
         IDLE: begin
            if (start) begin
               rdy_nxt     = 1'b0;
               cs_n_nxt    = 1'b0;
               sclk_nxt    = 1'b0;
               cnt_nxt     = '0;
               bit_cnt_nxt = '0;
               state_nxt   = (CS_SETUP > 0) ? SETUP : SHIFT;
            end
         end
         SETUP: begin
            if (cnt == SETUP_LAST) begin
               cnt_nxt   = '0;
               state_nxt = SHIFT;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         SHIFT: begin
            // SCLK only toggles when the phase counter expires, so it cannot glitch.
            if (cnt == DIV_LAST) begin
               cnt_nxt = '0;
               if (!spi_sclk_o) begin
                  sclk_nxt  = 1'b1;
                  shreg_nxt = {shreg[FRAME_BITS-2:0], spi_miso_i};
               end else begin
                  sclk_nxt = 1'b0;
                  if (bit_cnt == BIT_LAST) begin
                     cs_n_nxt  = 1'b1;
                     state_nxt = (QUIET > 1) ? CS_HOLD : PUBLISH;
                  end else begin
                     bit_cnt_nxt = bit_cnt + 1'b1;
                  end
               end
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         CS_HOLD: begin
            // The PUBLISH cycle is the last of the QUIET clocks.
            if (cnt == HOLD_LAST) begin
               cnt_nxt   = '0;
               state_nxt = PUBLISH;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         PUBLISH: begin
            data_nxt  = sample;
            ferr_nxt  = lead_err;
            rdy_nxt   = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         req_q          <= 1'b0;
         req_q_d        <= 1'b0;
         cnt            <= '0;
         bit_cnt        <= '0;
         shreg          <= '0;
         spi_sclk_o     <= 1'b0;
         spi_cs_n_o     <= 1'b1;
         adc_data_rdy_o <= 1'b1;
         adc_data_o     <= '0;
         frame_err_o    <= 1'b0;
         overrun_o      <= 1'b0;
      end else begin
         req_q          <= adc_data_req_i;
         req_q_d        <= req_q;
         cnt            <= cnt_nxt;
         bit_cnt        <= bit_cnt_nxt;
         shreg          <= shreg_nxt;
         spi_sclk_o     <= sclk_nxt;
         spi_cs_n_o     <= cs_n_nxt;
         adc_data_rdy_o <= rdy_nxt;
         adc_data_o     <= data_nxt;
         frame_err_o    <= ferr_nxt;
         overrun_o      <= ovr_nxt;
      end
   end

endmodule

`default_nettype wire
